sd_clk_gen: RTL and testbench

SD_CLK_GEN -- requirements
Module: sd_clk_gen

---
 rtl/sd_clk_gen.sv | 142 ++++++++++++++
 tb/tb_sd_clk_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_clk_gen.sv
// sd_clk_gen: programmable SD-card clock generator.
// Produces a registered, glitch-free sd_clk from clk. The output period is
// 2*(div+1) clk cycles. The generator runs continuously while en is held,
// or emits a burst of exactly burst_len rising edges on a burst_start pulse.
// A high phase always completes, and a new divider value takes effect only
// at a falling transition or at start, so sd_clk never shows a runt pulse.
module sd_clk_gen #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [CNT_W-1:0]   div,
  input  logic               burst_start,
  input  logic [BURST_W-1:0] burst_len,
  output logic               sd_clk,
  output logic               rise_stb,
  output logic               fall_stb,
  output logic               busy,
  output logic               burst_done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_LOW  = 2'd1,
    RUN_HIGH = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   div_q;
  logic [BURST_W-1:0] remaining;
  logic               burst_mode;
  logic               stop;

  // Stop request: a continuous run ends when en drops; a burst ends when
  // every requested rising edge has been issued. en has no effect in burst mode.
  always_comb begin
    stop = burst_mode ? (remaining == '0) : !en;
  end

  // Phase sequencer: owns the state, the phase counter, the burst
  // bookkeeping and every registered output.
  // NOTE: all sequential state uses non-blocking assignments so that each
  // register sees the pre-edge values of the others, however the block is ordered.
  always_ff @(posedge clk) begin
    // NOTE: every register here is a plain flop, not a memory, so the
    // synchronous reset clears all of it, including divider and burst counters.
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      div_q      <= '0;
      remaining  <= '0;
      burst_mode <= 1'b0;
      sd_clk     <= 1'b0;
      rise_stb   <= 1'b0;
      fall_stb   <= 1'b0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      // Strobes default low; each is raised only in its transition cycle.
      rise_stb   <= 1'b0;
      fall_stb   <= 1'b0;
      burst_done <= 1'b0;

      case (state)
        IDLE: begin
          sd_clk <= 1'b0;
          if (burst_start) begin
            // Burst takes priority over en.
            div_q <= div;
            cnt   <= '0;
            if (burst_len == '0) begin
              // Empty burst: report completion, generate no edges.
              burst_done <= 1'b1;
              remaining  <= '0;
              burst_mode <= 1'b0;
            end else begin
              remaining  <= burst_len;
              burst_mode <= 1'b1;
              state      <= RUN_LOW;
              busy       <= 1'b1;
            end
          end else if (en) begin
            div_q      <= div;
            cnt        <= '0;
            burst_mode <= 1'b0;
            state      <= RUN_LOW;
            busy       <= 1'b1;
          end
        end

        RUN_LOW: begin
          if (stop) begin
            // Leaving from the low phase: sd_clk is already 0, no strobe.
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == div_q) begin
            state    <= RUN_HIGH;
            sd_clk   <= 1'b1;
            rise_stb <= 1'b1;
            cnt      <= '0;
            if (burst_mode && remaining != '0) begin
              remaining <= remaining - 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RUN_HIGH: begin
          if (cnt == div_q) begin
            // Falling transition: the only point where a new divider is taken.
            sd_clk   <= 1'b0;
            fall_stb <= 1'b1;
            cnt      <= '0;
            div_q    <= div;
            if (stop) begin
              state      <= IDLE;
              busy       <= 1'b0;
              burst_done <= burst_mode;
              burst_mode <= 1'b0;
            end else begin
              state <= RUN_LOW;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          sd_clk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_clk_gen.sv
// tb_sd_clk_gen: directed and randomized bench for sd_clk_gen.
// A phase-countdown reference model predicts every output each cycle;
// directed steps add spec-level checks on period, phase length and edge counts.
module tb_sd_clk_gen;

  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic [CNT_W-1:0]   div;
  logic               burst_start;
  logic [BURST_W-1:0] burst_len;
  logic               sd_clk;
  logic               rise_stb;
  logic               fall_stb;
  logic               busy;
  logic               burst_done;

  always #5 clk = ~clk;

  sd_clk_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .div         (div),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .sd_clk      (sd_clk),
    .rise_stb    (rise_stb),
    .fall_stb    (fall_stb),
    .busy        (busy),
    .burst_done  (burst_done)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: generator either idle or running a phase of a given
  // level with a number of clk cycles still to go.
  bit m_active, m_level, m_burst, m_rise, m_fall, m_done;
  int m_half, m_left, m_edges;

  // Observation bookkeeping from the DUT outputs.
  int rise_cnt, fall_cnt, done_cnt;
  int hi_len, last_hi, last_rise_cyc, period;
  bit rose, fell, have_rise;

  task automatic check(string tag, logic obs, logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_stop();
    return m_burst ? (m_edges == 0) : !en;
  endfunction

  // Advance the model by one clk edge using the inputs sampled at that edge.
  task automatic model_edge();
    m_rise = 0; m_fall = 0; m_done = 0;
    if (!reset) begin
      m_active = 0; m_level = 0; m_burst = 0;
      m_half = 0; m_left = 0; m_edges = 0;
    end else if (!m_active) begin
      if (burst_start) begin
        if (burst_len == 0) begin
          m_done = 1;
        end else begin
          m_active = 1; m_burst = 1; m_edges = int'(burst_len);
          m_level = 0; m_half = int'(div) + 1; m_left = m_half;
        end
      end else if (en) begin
        m_active = 1; m_burst = 0;
        m_level = 0; m_half = int'(div) + 1; m_left = m_half;
      end
    end else if (!m_level) begin
      if (m_stop()) begin
        m_active = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_level = 1; m_rise = 1; m_left = m_half;
          if (m_burst) m_edges--;
        end
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_level = 0; m_fall = 1;
        m_half = int'(div) + 1; m_left = m_half;
        if (m_stop()) begin
          m_done = m_burst; m_active = 0; m_burst = 0;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, and compare all outputs.
  task automatic step(bit r, bit e, int d, bit bs, int bl);
    reset = r; en = e; div = CNT_W'(d); burst_start = bs; burst_len = BURST_W'(bl);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("sd_clk",     sd_clk,     m_active & m_level);
    check("rise_stb",   rise_stb,   m_rise);
    check("fall_stb",   fall_stb,   m_fall);
    check("busy",       busy,       m_active);
    check("burst_done", burst_done, m_done);
    rose = rise_stb; fell = fall_stb;
    if (!r) begin
      hi_len = 0; have_rise = 0;
    end
    if (sd_clk) hi_len++;
    if (fall_stb) begin last_hi = hi_len; hi_len = 0; fall_cnt++; end
    if (rise_stb) begin
      period = cyc - last_rise_cyc; last_rise_cyc = cyc; rise_cnt++;
    end
    if (burst_done) done_cnt++;
  endtask

  initial begin
    int falls_after;
    int rises_at_done;
    bit seen;

    reset = 0; en = 0; div = '0; burst_start = 0; burst_len = '0;

    // Reset state.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Continuous run, div=3: 8-cycle period, 4-cycle high phases.
    have_rise = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 3, 0, 0);
      if (rose) begin
        if (have_rise) check_int("run_period", period, 8);
        have_rise = 1;
      end
      if (fell) check_int("run_high_len", last_hi, 4);
    end
    for (int i = 0; i < 12; i++) step(1, 0, 3, 0, 0);
    check("run_stopped_busy", busy, 1'b0);

    // Divider change one cycle into a high phase: that phase stays 4 long.
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1, 1, 3, 0, 0);
      seen = rose;
    end
    check("div_chg_rise_seen", seen, 1'b1);
    falls_after = 0;
    for (int i = 0; i < 24; i++) begin
      step(1, 1, 1, 0, 0);
      if (fell) begin
        check_int("div_chg_high_len", last_hi, (falls_after == 0) ? 4 : 2);
        falls_after++;
      end
      if (rose && falls_after > 1) check_int("div_chg_period", period, 4);
    end
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0);

    // Stop one cycle into the high phase: phase completes, then idle.
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1, 1, 3, 0, 0);
      seen = rose;
    end
    check("stop_rise_seen", seen, 1'b1);
    step(1, 1, 3, 0, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1, 0, 3, 0, 0);
      seen = fell;
    end
    check("stop_fall_seen", seen, 1'b1);
    check_int("stop_high_len", last_hi, 4);
    check("stop_busy", busy, 1'b0);
    for (int i = 0; i < 5; i++) step(1, 0, 3, 0, 0);
    check("stop_sd_clk_parked", sd_clk, 1'b0);

    // Burst of 74 at clk/2.
    rise_cnt = 0; done_cnt = 0; seen = 0; rises_at_done = -1;
    step(1, 0, 0, 1, 74);
    for (int i = 0; i < 400 && !seen; i++) begin
      step(1, 0, 0, 0, 0);
      if (burst_done) begin
        seen = 1; rises_at_done = rise_cnt;
        check("burst_done_with_fall", fall_stb, 1'b1);
      end
    end
    check("burst74_done_seen", seen, 1'b1);
    check_int("burst74_rises", rises_at_done, 74);
    step(1, 0, 0, 0, 0);
    check("burst74_idle", busy, 1'b0);
    check_int("burst74_single_done", done_cnt, 1);

    // Empty burst: done next cycle, no edges, never busy.
    rise_cnt = 0; done_cnt = 0;
    step(1, 0, 2, 1, 0);
    check("burst0_busy", busy, 1'b0);
    check("burst0_done_next", burst_done, 1'b1);
    for (int i = 0; i < 6; i++) step(1, 0, 2, 0, 0);
    check_int("burst0_rises", rise_cnt, 0);
    check_int("burst0_single_done", done_cnt, 1);

    // Burst with en held: burst of 3 first, then continuous run resumes.
    rise_cnt = 0; done_cnt = 0;
    step(1, 1, 1, 1, 3);
    for (int i = 0; i < 50; i++) step(1, 1, 1, 0, 0);
    check_int("burst_en_done", done_cnt, 1);
    check("burst_en_resumed", busy, 1'b1);
    check("burst_en_more_edges", rise_cnt > 3, 1'b1);
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 0);

    // Reset at the 10th edge of a 20-edge burst.
    rise_cnt = 0; done_cnt = 0; seen = 0;
    step(1, 0, 1, 1, 20);
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1, 0, 1, 0, 0);
      seen = (rise_cnt == 10);
    end
    check("rst_burst_10th_edge", seen, 1'b1);
    step(0, 0, 1, 0, 0);
    check("rst_burst_busy", busy, 1'b0);
    check("rst_burst_sd_clk", sd_clk, 1'b0);
    for (int i = 0; i < 40; i++) step(1, 0, 1, 0, 0);
    check_int("rst_burst_no_done", done_cnt, 0);

    // Randomized traffic against the model.
    begin
      bit r_en = 0;
      for (int i = 0; i < 4000; i++) begin
        bit r_rst = ($urandom_range(0, 199) != 0);
        bit r_bs  = ($urandom_range(0, 14) == 0);
        if ($urandom_range(0, 19) == 0) r_en = ~r_en;
        step(r_rst, r_en, $urandom_range(0, 3), r_bs, $urandom_range(0, 4));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
